// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC_DEFAULT  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } pc_seq_state_t;

    // Instruction word plus the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_pkt_t;

    // Redirect target held while an issued fetch is still outstanding
    typedef struct packed {
        logic            trap;
        logic [XLEN-1:0] pc;
    } pend_tgt_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-stage bundle: PC register control, instruction memory port and decode handoff.
interface pc_fetch_sequencer_if;
    import pc_seq_pkg::*;

    logic [XLEN-1:0] pc_current;
    logic            pc_write;
    logic [XLEN-1:0] pc_next;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            trap;

    modport master (
        input  pc_current, imem_ready, imem_rdata, stall, redirect, redirect_pc, trap,
        output pc_write, pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output pc_current, imem_ready, imem_rdata, stall, redirect, redirect_pc, trap,
        input  pc_write, pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: drives the external PC register and sequences one-in-flight
// instruction fetches, handling wait states, decode stalls, redirects and traps.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter logic [XLEN-1:0] TRAP_VEC  = TRAP_VEC_DEFAULT
) (
    input logic                 clk,
    input logic                 reset_n,
    pc_fetch_sequencer_if.master bus
);

    pc_seq_state_t   state, state_n;
    fetch_pkt_t      fetched, fetched_n;
    pend_tgt_t       pend, pend_n;
    logic            kill_pending, kill_n;

    logic            pc_write_c;
    logic [XLEN-1:0] pc_next_c;
    logic            imem_req_c;

    logic            redir_any;
    logic            keep_trap;
    logic [XLEN-1:0] req_tgt;
    logic [XLEN-1:0] pc_seq;

    // A new trap wins over everything; a redirect never displaces a pending trap
    assign redir_any = bus.trap | bus.redirect;
    assign keep_trap = kill_pending & pend.trap & ~bus.trap;
    assign req_tgt   = bus.trap ? TRAP_VEC : align_word(bus.redirect_pc);
    assign pc_seq    = bus.pc_current + XLEN'(INSTR_BYTES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= BOOT;
            fetched      <= '0;
            pend         <= '0;
            kill_pending <= 1'b0;
        end else begin
            state        <= state_n;
            fetched      <= fetched_n;
            pend         <= pend_n;
            kill_pending <= kill_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetched_n  = fetched;
        pend_n     = pend;
        kill_n     = kill_pending;
        pc_write_c = 1'b0;
        pc_next_c  = bus.pc_current;
        imem_req_c = 1'b0;

        case (state)
            BOOT: begin
                pc_write_c = 1'b1;
                pc_next_c  = RESET_VEC;
                state_n    = REQ;
            end

            REQ, WAIT: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    if (redir_any || kill_pending) begin
                        // Returned word belongs to the squashed path: drop it
                        pc_write_c = 1'b1;
                        pc_next_c  = (redir_any && !keep_trap) ? req_tgt : pend.pc;
                        kill_n     = 1'b0;
                        pend_n     = '0;
                        state_n    = REQ;
                    end else begin
                        fetched_n = '{pc: bus.pc_current, word: bus.imem_rdata};
                        state_n   = VALID;
                    end
                end else begin
                    state_n = WAIT;
                    if (redir_any) begin
                        kill_n = 1'b1;
                        if (!keep_trap) begin
                            pend_n = '{trap: bus.trap, pc: req_tgt};
                        end
                    end
                end
            end

            VALID: begin
                if (bus.trap) begin
                    pc_write_c = 1'b1;
                    pc_next_c  = TRAP_VEC;
                    state_n    = REQ;
                end else if (bus.redirect) begin
                    pc_write_c = 1'b1;
                    pc_next_c  = align_word(bus.redirect_pc);
                    state_n    = REQ;
                end else if (!bus.stall) begin
                    pc_write_c = 1'b1;
                    pc_next_c  = pc_seq;
                    state_n    = REQ;
                end
            end

            default: begin
                state_n = BOOT;
            end
        endcase
    end

    assign bus.pc_write    = pc_write_c;
    assign bus.pc_next     = pc_next_c;
    assign bus.imem_req    = imem_req_c;
    assign bus.imem_addr   = bus.pc_current;
    assign bus.instr_valid = (state == VALID);
    assign bus.instr       = fetched.word;
    assign bus.instr_pc    = fetched.pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with an external PC register and memory model.
module tb_pc_fetch_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   errors  = 0;
    logic prev_v  = 1'b0;

    fetch_pkt_t sb[$];

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // External PC register and zero-latency-data memory
    logic [31:0] pc_reg;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         pc_reg <= 32'h0;
        else if (bus.pc_write) pc_reg <= bus.pc_next;
    end
    assign bus.pc_current = pc_reg;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a);
        sb.push_back('{pc: a, word: mem_word(a)});
    endtask

    // Advance to the next falling edge and score any newly presented instruction
    task automatic tick();
        fetch_pkt_t e;
        @(negedge clk);
        if (bus.instr_valid && !prev_v) begin
            vectors++;
            assert (sb.size() != 0)
            else begin
                errors++;
                $error("FAIL sb_unexpected observed=%h expected=none", bus.instr_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_instr_pc", bus.instr_pc, e.pc);
                chk("sb_instr", bus.instr, e.word);
            end
        end
        prev_v = bus.instr_valid;
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.imem_ready  = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.trap        = 1'b0;

        tick(); tick(); #1;
        chk("rst_pc_write", 32'(bus.pc_write), 32'h1);
        chk("rst_pc_next", bus.pc_next, 32'h0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);

        tick(); reset_n = 1'b1; #1;
        chk("boot_pc_write", 32'(bus.pc_write), 32'h1);
        chk("boot_pc_next", bus.pc_next, 32'h0);

        tick(); #1;
        chk("req0_imem_req", 32'(bus.imem_req), 32'h1);
        chk("req0_addr", bus.imem_addr, 32'h0);
        chk("req0_pc_write", 32'(bus.pc_write), 32'h0);
        push_fetch(32'h0);

        tick(); #1;
        chk("v0_instr_valid", 32'(bus.instr_valid), 32'h1);
        chk("v0_pc_next", bus.pc_next, 32'h4);

        // Three wait cycles on the fetch at 0x4
        tick(); bus.imem_ready = 1'b0; #1;
        chk("w_req", 32'(bus.imem_req), 32'h1);
        chk("w_addr", bus.imem_addr, 32'h4);
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            chk("w_req", 32'(bus.imem_req), 32'h1);
            chk("w_addr", bus.imem_addr, 32'h4);
        end
        tick(); bus.imem_ready = 1'b1; #1;
        chk("w_ready_addr", bus.imem_addr, 32'h4);
        chk("w_ready_valid", 32'(bus.instr_valid), 32'h0);
        push_fetch(32'h4);
        tick(); #1;
        chk("w_after_valid", 32'(bus.instr_valid), 32'h1);
        chk("v4_pc_next", bus.pc_next, 32'h8);

        // Decode stall for two cycles at 0x8
        tick(); #1;
        chk("req8_addr", bus.imem_addr, 32'h8);
        push_fetch(32'h8);
        tick(); bus.stall = 1'b1; #1;
        chk("stall_pc_write", 32'(bus.pc_write), 32'h0);
        chk("stall_instr_pc", bus.instr_pc, 32'h8);
        tick(); #1;
        chk("stall2_pc_write", 32'(bus.pc_write), 32'h0);
        chk("stall2_valid", 32'(bus.instr_valid), 32'h1);
        chk("stall2_instr", bus.instr, mem_word(32'h8));
        tick(); bus.stall = 1'b0; #1;
        chk("unstall_pc_write", 32'(bus.pc_write), 32'h1);
        chk("unstall_pc_next", bus.pc_next, 32'hC);

        // Redirect during WAIT, unaligned target
        tick(); bus.imem_ready = 1'b0; #1;
        chk("reqC_addr", bus.imem_addr, 32'hC);
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h1003; #1;
        chk("kill_set_pc_write", 32'(bus.pc_write), 32'h0);
        chk("kill_set_req", 32'(bus.imem_req), 32'h1);
        tick(); bus.redirect = 1'b0; bus.imem_ready = 1'b1; #1;
        chk("kill_ready_pc_write", 32'(bus.pc_write), 32'h1);
        chk("kill_ready_pc_next", bus.pc_next, 32'h1000);
        tick(); #1;
        chk("kill_next_addr", bus.imem_addr, 32'h1000);
        chk("kill_no_valid", 32'(bus.instr_valid), 32'h0);
        push_fetch(32'h1000);

        // Trap beats redirect in VALID
        tick(); bus.trap = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h2000; #1;
        chk("trap_pc_write", 32'(bus.pc_write), 32'h1);
        chk("trap_pc_next", bus.pc_next, 32'h100);
        tick(); bus.trap = 1'b0; bus.redirect = 1'b0; #1;
        chk("trap_addr", bus.imem_addr, 32'h100);
        push_fetch(32'h100);

        // PC wrap at the top of the address space
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; #1;
        chk("top_pc_next", bus.pc_next, 32'hFFFF_FFFC);
        tick(); bus.redirect = 1'b0; #1;
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        push_fetch(32'hFFFF_FFFC);
        tick(); #1;
        chk("wrap_pc_next", bus.pc_next, 32'h0);

        // Pending trap survives a later redirect
        tick(); bus.imem_ready = 1'b0; bus.trap = 1'b1; #1;
        chk("ptrap_addr", bus.imem_addr, 32'h0);
        tick(); bus.trap = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h3000; #1;
        chk("ptrap_pc_write", 32'(bus.pc_write), 32'h0);
        tick(); bus.redirect = 1'b0; bus.imem_ready = 1'b1; #1;
        chk("ptrap_pc_next", bus.pc_next, 32'h100);

        // Redirect in REQ with memory ready in the same cycle
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h44; #1;
        chk("req_redir_pc_write", 32'(bus.pc_write), 32'h1);
        chk("req_redir_pc_next", bus.pc_next, 32'h44);
        tick(); bus.redirect = 1'b0; bus.imem_ready = 1'b0; #1;
        chk("req_redir_addr", bus.imem_addr, 32'h44);
        chk("req_redir_no_valid", 32'(bus.instr_valid), 32'h0);

        // Reset mid-WAIT with a redirect pending
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h5000; #1;
        tick(); bus.redirect = 1'b0; #3;
        reset_n = 1'b0; #1;
        chk("arst_imem_req", 32'(bus.imem_req), 32'h0);
        chk("arst_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("arst_pc_write", 32'(bus.pc_write), 32'h1);
        chk("arst_pc_next", bus.pc_next, 32'h0);
        tick(); bus.imem_ready = 1'b1; reset_n = 1'b1; #1;
        chk("reboot_pc_next", bus.pc_next, 32'h0);
        tick(); #1;
        chk("reboot_addr", bus.imem_addr, 32'h0);
        push_fetch(32'h0);
        tick(); #1;
        chk("reboot_pc_next4", bus.pc_next, 32'h4);
        tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-stage controller that owns the program counter register's `pc_write`/`pc_next` inputs and sequences instruction fetch from instruction memory. It handles the boot vector, memory wait states, decode-stage stalls, branch/jump redirects and trap entry. It sits between the program counter register, the instruction memory port and the decode stage. It issues at most one fetch in flight.

## Interface
- `RESET_VEC`, 32'h0000_0000, first PC loaded after reset
- `TRAP_VEC`, 32'h0000_0100, PC loaded on `trap`

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `pc_current`  in  32  current value of the PC register
- `pc_write`  out  1  PC register write enable
- `pc_next`  out  32  value written into the PC register
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; combinational copy of `pc_current`
- `imem_ready`  in  1  memory accepts the request and returns `imem_rdata` this cycle
- `imem_rdata`  in  32  fetched instruction
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid instruction
- `instr`  out  32  captured instruction
- `instr_pc`  out  32  address `instr` was fetched from
- `stall`  in  1  decode cannot accept `instr` this cycle
- `redirect`  in  1  branch/jump taken
- `redirect_pc`  in  32  redirect target
- `trap`  in  1  trap entry request

## Operation
- FSM states: BOOT, REQ, WAIT, VALID. Reset state is BOOT.
- **BOOT**
  - Drives `pc_write=1` and `pc_next=RESET_VEC`.
  - Moves to REQ unconditionally.
- **REQ**
  - Drives `imem_req=1`.
  - With `imem_ready=1`: captures `imem_rdata` and `pc_current`, then moves to VALID.
  - With `imem_ready=0`: moves to WAIT.
- **WAIT**
  - Holds `imem_req=1`; the address is stable because the PC is not written.
  - Moves on `imem_ready` exactly as REQ does.
- **VALID**
  - Drives `instr_valid=1`.
  - `trap`: `pc_next=TRAP_VEC`, then REQ.
  - Else `redirect`: `pc_next=redirect_pc`, then REQ.
  - Else `stall`: holds everything, no `pc_write`.
  - Else: `pc_next=pc_current+4`, then REQ.
  - Every exit from VALID pulses `pc_write` for one cycle.
- **Redirect priority:** `trap` > `redirect` > `stall` > sequential.
- **Target alignment:** `redirect_pc[1:0]` is forced to 2'b00.
- **Redirect or trap in REQ or WAIT:**
  - An issued request is never aborted.
  - With `imem_ready=1` in the same cycle: the fetched data is discarded, `pc_write` loads the target, and the state stays/returns to REQ.
  - With `imem_ready=0`: the target is stored in a pending register and `kill_pending` is set.
  - A later redirect or trap overwrites the pending target. A trap is never overwritten by a redirect.
  - When `imem_ready` arrives with `kill_pending` set: the data is discarded, `pc_write` loads the pending target, `kill_pending` clears, and the state moves to REQ.
- **Arithmetic:** `pc_current+4` is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0.
- **Reset values while `reset_n`=0:**
  - `pc_write=1`, `pc_next=RESET_VEC` (BOOT outputs; harmless because the PC register is also in reset).
  - `imem_req=0`, `instr_valid=0`, `instr=0`, `instr_pc=0`, `kill_pending=0`.
  - `imem_addr` follows `pc_current`.

## Timing
- Zero-wait memory: BOOT→REQ→VALID→REQ…, i.e. one instruction per 2 cycles.
- `instr_valid` rises on the clock edge after the `imem_req && imem_ready` cycle.
- Each memory wait cycle adds one cycle.
- `pc_write` is combinational from state and inputs. The PC register updates on the same edge that leaves VALID.
- The first fetch address equals `RESET_VEC` in the cycle after BOOT.
- Reset asserted mid-operation takes effect immediately (asynchronously):
  - `imem_req` and `instr_valid` drop.
  - Any pending redirect is lost.
- After reset deasserts, the first `clk` edge executes BOOT.

## Structure
- Package `pc_seq_pkg` holds:
  - the state enum `pc_seq_state_t` (BOOT, REQ, WAIT, VALID);
  - `INSTR_BYTES=4`;
  - defaults for `RESET_VEC` and `TRAP_VEC`.
- Single flat module with no sub-modules. The PC register stays external and is instantiated beside this block by the fetch-stage parent.
- Internal registers: state, `instr`, `instr_pc`, `kill_pending`, pending target.

## Test plan
- Release reset with `imem_ready` tied 1 and no stall → first cycle `pc_write=1`, `pc_next=0x0`; fetches at 0x0, 0x4, 0x8; `instr_valid` pulses every second cycle with matching `instr_pc`.
- `imem_ready` low for 3 cycles on the fetch at 0x4 → `imem_req` high and `imem_addr=0x4` throughout; `instr_valid` rises one cycle after `imem_ready`.
- `stall` high 2 cycles in VALID at PC 0x8 → `instr` and `instr_pc` held and no `pc_write`; on release `pc_next=0xC`.
- `redirect` with `redirect_pc=0x1003` during WAIT → the returned word is never presented; `pc_next=0x1000` on the `imem_ready` cycle; next `imem_addr=0x1000`.
- `trap` and `redirect` (0x2000) in the same VALID cycle → `pc_next=0x100`.
- Two boundary cases:
  - With `pc_current=0xFFFF_FFFC` in VALID → `pc_next=0x0`.
  - Assert `reset_n=0` mid-WAIT → `imem_req=0` and `instr_valid=0` immediately; after release, BOOT reloads 0x0.
